// File: rtl/button_ctrl.sv
// Button front end: 2-flop sync, per-button debounce, press pulse, control word {col, spd, en}.
// Press pulse at DEB_LIMIT+3 edges after input rise, o_sw one edge later; no backpressure, never stalls.
module button_ctrl #(
    parameter int N_BTN     = 4,
    parameter int NB_SW     = 4,
    parameter int NB_DEB    = 20,
    parameter int DEB_LIMIT = 999999
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [NB_SW-1:0] o_sw,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_stable
);

    localparam logic [NB_DEB-1:0] LP_LIMIT = NB_DEB'(DEB_LIMIT);

    logic [N_BTN-1:0]  r_s1;
    logic [N_BTN-1:0]  r_s2;
    logic [N_BTN-1:0]  r_stable;
    logic [N_BTN-1:0]  r_stable_prev;
    logic [N_BTN-1:0]  r_press;
    logic [NB_DEB-1:0] r_cnt [N_BTN];

    logic              r_en;
    logic [1:0]        r_spd;
    logic              r_col;
    logic [1:0]        w_spd_nxt;
    logic [3:0]        w_sw;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

    // A level is accepted only after DEB_LIMIT+1 consecutive mismatching samples.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_stable <= '0;
            for (int k = 0; k < N_BTN; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_BTN; k++) begin
                if (r_s2[k] == r_stable[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == LP_LIMIT) begin
                    r_stable[k] <= r_s2[k];
                    r_cnt[k]    <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_stable_prev <= '0;
            r_press       <= '0;
        end else begin
            r_stable_prev <= r_stable;
            r_press       <= r_stable & ~r_stable_prev;
        end
    end

    // Up and down on the same cycle cancel out.
    always_comb begin
        w_spd_nxt = r_spd;
        if (r_press[1] && !r_press[2]) begin
            w_spd_nxt = r_spd + 2'd1;
        end else if (r_press[2] && !r_press[1]) begin
            w_spd_nxt = r_spd - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_en  <= 1'b0;
            r_spd <= 2'd0;
            r_col <= 1'b0;
        end else begin
            r_en  <= r_en ^ r_press[0];
            r_spd <= w_spd_nxt;
            r_col <= r_col ^ r_press[3];
        end
    end

    assign w_sw     = {r_col, r_spd, r_en};
    assign o_sw     = NB_SW'(w_sw);
    assign o_press  = r_press;
    assign o_stable = r_stable;

endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl with a short debounce (DEB_LIMIT=3).
module tb_button_ctrl;

    logic       clk;
    logic       i_reset;
    logic [3:0] i_btn;
    logic [3:0] o_sw;
    logic [3:0] o_press;
    logic [3:0] o_stable;

    int n_tests = 0;
    int n_fail  = 0;
    int np [4];
    int base;
    int exp_spd [5] = '{1, 2, 3, 0, 1};

    button_ctrl #(
        .N_BTN    (4),
        .NB_SW    (4),
        .NB_DEB   (4),
        .DEB_LIMIT(3)
    ) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .i_btn   (i_btn),
        .o_sw    (o_sw),
        .o_press (o_press),
        .o_stable(o_stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < 4; k++) np[k] = 0;
    end

    // Count cycles each press bit is high, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (o_press[k] === 1'b1) np[k] = np[k] + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Press a button mask, check the pulse timing, hold, release, let the release settle.
    task automatic press_mask(input logic [3:0] mask, input string tag);
        i_btn = mask;
        tick(7);
        chk({tag, "_press"}, 32'(o_press), 32'(mask));
        tick(1);
        chk({tag, "_press_end"}, 32'(o_press), 32'h0);
        tick(5);
        i_btn = 4'h0;
        tick(10);
    endtask

    initial begin
        // 1. reset with all buttons high
        i_reset = 1'b1;
        i_btn   = 4'hF;
        tick(3);
        chk("rst_sw", 32'(o_sw), 32'h0);
        chk("rst_press", 32'(o_press), 32'h0);
        chk("rst_stable", 32'(o_stable), 32'h0);
        i_btn   = 4'h0;
        i_reset = 1'b0;
        tick(4);

        // 2. glitch of 3 samples, one short of acceptance
        base  = np[0];
        i_btn = 4'h1;
        tick(3);
        i_btn = 4'h0;
        tick(12);
        chk("glitch_stable", 32'(o_stable), 32'h0);
        chk("glitch_sw", 32'(o_sw), 32'h0);
        chk("glitch_npress", 32'(np[0] - base), 32'h0);

        // 3. exact press latency, then hold/release and toggle back
        base  = np[0];
        i_btn = 4'h1;
        tick(5);
        chk("lat_stable_e4", 32'(o_stable[0]), 32'h0);
        tick(1);
        chk("lat_stable_e5", 32'(o_stable[0]), 32'h1);
        chk("lat_press_e5", 32'(o_press), 32'h0);
        tick(1);
        chk("lat_press_e6", 32'(o_press), 32'h1);
        chk("lat_sw_e6", 32'(o_sw), 32'h0);
        tick(1);
        chk("lat_press_e7", 32'(o_press), 32'h0);
        chk("lat_sw_e7", 32'(o_sw), 32'h1);
        tick(5);
        i_btn = 4'h0;
        tick(10);
        chk("hold_npress", 32'(np[0] - base), 32'h1);
        chk("release_stable", 32'(o_stable), 32'h0);
        chk("release_sw", 32'(o_sw), 32'h1);
        press_mask(4'h1, "en_off");
        chk("en_off_sw", 32'(o_sw), 32'h0);

        // 4. speed up with wrap, then speed down with wrap
        for (int i = 0; i < 5; i++) begin
            press_mask(4'h2, "spd_up");
            chk("spd_up", 32'(o_sw[2:1]), 32'(exp_spd[i]));
        end
        press_mask(4'h4, "spd_dn1");
        chk("spd_dn1", 32'(o_sw[2:1]), 32'h0);
        press_mask(4'h4, "spd_dn_wrap");
        chk("spd_dn_wrap", 32'(o_sw[2:1]), 32'h3);
        press_mask(4'h4, "spd_dn2");
        chk("spd_dn2", 32'(o_sw), 32'h4);

        // 5. simultaneous presses
        press_mask(4'h6, "spd_both");
        chk("spd_both", 32'(o_sw), 32'h4);
        press_mask(4'h4, "spd_to1");
        press_mask(4'h4, "spd_to0");
        chk("spd_zero", 32'(o_sw), 32'h0);
        press_mask(4'h9, "col_en");
        chk("col_en_sw", 32'(o_sw), 32'h9);

        // 6. reset while btn0 debounce count is 2
        base  = np[0];
        i_btn = 4'h1;
        tick(4);
        i_reset = 1'b1;
        tick(1);
        chk("midrst_sw", 32'(o_sw), 32'h0);
        chk("midrst_stable", 32'(o_stable), 32'h0);
        chk("midrst_press", 32'(o_press), 32'h0);
        i_reset = 1'b0;
        tick(5);
        chk("midrst_stable_e4", 32'(o_stable[0]), 32'h0);
        tick(1);
        chk("midrst_stable_e5", 32'(o_stable[0]), 32'h1);
        tick(1);
        chk("midrst_press_e6", 32'(o_press), 32'h1);
        tick(1);
        chk("midrst_sw_e7", 32'(o_sw), 32'h1);
        tick(4);
        i_btn = 4'h0;
        tick(10);
        chk("midrst_npress", 32'(np[0] - base), 32'h1);
        chk("midrst_final_sw", 32'(o_sw), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
